// File: rtl/saph_pixel_packer_pkg.sv
// Shared types for the pixel packer: pixel format, ARGB colour, packer FSM
// states, and format-legality helpers. These are the saph_types additions
// (SAPH_PIXTYPE_*, pix_size_ok) used by the packer and by saph_pix_encode.
package saph_pixel_packer_pkg;

  localparam logic [3:0] SAPH_PIXTYPE_RGB  = 4'd0;
  localparam logic [3:0] SAPH_PIXTYPE_ARGB = 4'd1;

  // ARGB8888 pixel
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  // One channel: bit position in the packed pixel and width-1
  typedef struct packed {
    logic [4:0] pos;
    logic [2:0] w;
  } chan_t;

  // Pixel format: category, pixel size-1 (S = size+1) and four channels
  typedef struct packed {
    logic [3:0] cat;
    logic [4:0] size;
    chan_t      a;
    chan_t      r;
    chan_t      g;
    chan_t      b;
  } pixfmt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pack_state_t;

  // True when S = size+1 is a power of two
  function automatic logic pix_size_ok(input bit [4:0] size);
    logic [5:0] s;
    s = {1'b0, size} + 6'd1;
    return (s & (s - 6'd1)) == 6'd0;
  endfunction

  // log2(S) for the legal sizes; only meaningful after pix_size_ok
  function automatic logic [2:0] pix_size_log2(input logic [4:0] size);
    logic [2:0] l;
    case (size)
      5'd0:    l = 3'd0;
      5'd1:    l = 3'd1;
      5'd3:    l = 3'd2;
      5'd7:    l = 3'd3;
      5'd15:   l = 3'd4;
      5'd31:   l = 3'd5;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/saph_pixel_packer_if.sv
// Pixel-in / word-out stream bundle of the pixel packer.
// slave  : the packer side (consumes pixels, produces words)
// master : the producer/consumer side around the packer
interface saph_pixel_packer_if #(
  parameter int BUS_W = 32
);
  import saph_pixel_packer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  color_t             in_color;
  logic [1:0]         in_x;
  logic [1:0]         in_y;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [BUS_W-1:0]   out_data;
  logic [BUS_W/8-1:0] out_strb;
  logic               out_last;

  modport slave (
    input  in_valid, in_color, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_data, out_strb, out_last
  );

  modport master (
    output in_valid, in_color, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_strb, out_last
  );

endinterface

// File: rtl/saph_pix_encode.sv
// Combinational ARGB -> packed pixel encoder. Each channel keeps its top
// w+1 bits, is shifted to its position, and bits at or above S are dropped.
// Alpha only contributes in the ARGB category.
// Optional feature macro: SAPH_PIXPACK_DITHER_EN adds a 4x4 ordered Bayer
// dither to R/G/B before truncation; without it in_x/in_y are not ports.
module saph_pix_encode
  import saph_pixel_packer_pkg::*;
(
  input  color_t      i_color,
  input  pixfmt_t     i_fmt,
`ifdef SAPH_PIXPACK_DITHER_EN
  input  logic [1:0]  i_x,
  input  logic [1:0]  i_y,
`endif
  output logic [31:0] o_pix
);

  // Top w+1 bits of an 8-bit channel placed at its bit position
  function automatic logic [31:0] chan_place(input logic [7:0] c, input chan_t ch);
    logic [7:0] v;
    v = c >> (3'd7 - ch.w);
    return {24'd0, v} << ch.pos;
  endfunction

`ifdef SAPH_PIXPACK_DITHER_EN
  // 4x4 ordered Bayer threshold, row = y, column = x
  function automatic logic [3:0] bayer(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] t;
    case ({y, x})
      4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
      4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
      4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
      4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  4'hF: t = 4'd5;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

  // Add the threshold scaled to the target width, saturating at full scale
  function automatic logic [7:0] dither(input logic [7:0] c, input logic [2:0] w,
                                        input logic [3:0] t);
    logic [8:0] sum;
    sum = {1'b0, c} + {1'b0, ({t, 4'h0} >> w)};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction
`endif

  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;
  logic [31:0] w_pix;

  // Build the pixel: optional dither, truncate/place channels, clip to S bits
  always_comb begin
    w_r = i_color.r;
    w_g = i_color.g;
    w_b = i_color.b;
`ifdef SAPH_PIXPACK_DITHER_EN
    w_r = dither(i_color.r, i_fmt.r.w, bayer(i_x, i_y));
    w_g = dither(i_color.g, i_fmt.g.w, bayer(i_x, i_y));
    w_b = dither(i_color.b, i_fmt.b.w, bayer(i_x, i_y));
`endif
    w_pix = chan_place(w_r, i_fmt.r) | chan_place(w_g, i_fmt.g) | chan_place(w_b, i_fmt.b);
    if (i_fmt.cat == SAPH_PIXTYPE_ARGB) begin
      w_pix = w_pix | chan_place(i_color.a, i_fmt.a);
    end else begin
      w_pix = w_pix;
    end
    o_pix = w_pix & (32'hFFFF_FFFF >> (5'd31 - i_fmt.size));
  end

endmodule

// File: rtl/saph_pixel_packer.sv
// Pixel packer: accepts encoded pixels, concatenates them little-endian into
// BUS_W-bit words with byte strobes, and flushes a partial word on in_last.
// Owns the run FSM, accumulator, slot counter and output register.
// Optional feature macro: SAPH_PIXPACK_DITHER_EN (ordered dither in the encoder).
module saph_pixel_packer
  import saph_pixel_packer_pkg::*;
#(
  parameter int BUS_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  pixfmt_t            cfg_fmt,
  input  logic               cfg_start,
  output logic               cfg_err,
  output logic               busy,
  saph_pixel_packer_if.slave bus
);

  localparam int CNT_W  = $clog2(BUS_W);
  localparam int STRB_W = BUS_W / 8;

  typedef logic [CNT_W:0]   cntx_t;
  typedef logic [BUS_W-1:0] word_t;

  pack_state_t       r_state;
  pixfmt_t           r_fmt;
  logic              r_cfg_err;
  word_t             r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  word_t             r_out_data;
  logic [STRB_W-1:0] r_out_strb;
  logic              r_out_last;

  logic [31:0]       w_pix;
  logic [2:0]        w_sl;
  cntx_t             w_ppw_m1;
  cntx_t             w_offset;
  cntx_t             w_bits;
  logic              w_completes;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  word_t             w_word;
  logic [STRB_W-1:0] w_strb;

  saph_pix_encode u_encode (
    .i_color (bus.in_color),
    .i_fmt   (r_fmt),
`ifdef SAPH_PIXPACK_DITHER_EN
    .i_x     (bus.in_x),
    .i_y     (bus.in_y),
`endif
    .o_pix   (w_pix)
  );

  // Slot arithmetic, word completion, handshakes and the candidate output word
  always_comb begin
    w_sl        = pix_size_log2(r_fmt.size);
    w_ppw_m1    = cntx_t'((BUS_W >> w_sl) - 1);
    w_completes = ({1'b0, r_cnt} == w_ppw_m1) | bus.in_last;
    w_in_ready  = (r_state == ST_RUN) & (~r_out_valid | bus.out_ready | ~w_completes);
    w_in_fire   = bus.in_valid & w_in_ready;
    w_out_fire  = r_out_valid & bus.out_ready;
    w_offset    = {1'b0, r_cnt} << w_sl;
    w_bits      = ({1'b0, r_cnt} + cntx_t'(1)) << w_sl;
    w_word      = r_acc | (word_t'(w_pix) << w_offset);
    w_strb      = '0;
    for (int j = 0; j < STRB_W; j++) begin
      w_strb[j] = (cntx_t'(j * 8) < w_bits);
    end
  end

  // Run FSM, accumulator/slot counter and registered output word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fmt       <= '0;
      r_cfg_err   <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire && w_completes) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_strb  <= w_strb;
        r_out_last  <= bus.in_last;
      end
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (pix_size_ok(cfg_fmt.size) &&
                (cfg_fmt.cat == SAPH_PIXTYPE_RGB || cfg_fmt.cat == SAPH_PIXTYPE_ARGB)) begin
              r_fmt     <= cfg_fmt;
              r_cfg_err <= 1'b0;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_state   <= ST_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_in_fire) begin
            if (w_completes) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= w_word;
              r_cnt <= r_cnt + 1'b1;
            end
            if (bus.in_last) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_out_fire && r_out_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_err       = r_cfg_err;
  assign busy          = (r_state != ST_IDLE);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_strb  = r_out_strb;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_saph_pixel_packer.sv
// Self-checking bench for saph_pixel_packer (BUS_W = 32): fixed vectors plus
// randomized runs compared against an arithmetic packing model.
`timescale 1ns/1ps
module tb_saph_pixel_packer;
  import saph_pixel_packer_pkg::*;

  localparam int BUS_W = 32;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wrd_t;

  logic    clk       = 1'b0;
  logic    rst_n     = 1'b0;
  pixfmt_t cfg_fmt   = '0;
  logic    cfg_start = 1'b0;
  logic    cfg_err;
  logic    busy;
  logic    rdy_force = 1'b1;
  logic    rdy_rand  = 1'b0;
  logic    rdy_q     = 1'b0;
  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;
  color_t  px_q[$];
  wrd_t    exp_q[$];
  wrd_t    got_q[$];
  int      fire_q[$];

  saph_pixel_packer_if #(.BUS_W(BUS_W)) bus ();

  saph_pixel_packer #(.BUS_W(BUS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_fmt   (cfg_fmt),
    .cfg_start (cfg_start),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  assign bus.out_ready = rdy_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_q <= rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_data, bus.out_strb, bus.out_last});
    if (bus.in_valid && bus.in_ready) fire_q.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic longint unsigned m_chan(logic [7:0] c, chan_t ch);
    int wd = int'(ch.w) + 1;
    return (longint'(c) / (64'd1 << (8 - wd))) * (64'd1 << ch.pos);
  endfunction

  function automatic longint unsigned m_pix(pixfmt_t f, color_t c);
    longint unsigned v;
    int s = int'(f.size) + 1;
    v = m_chan(c.r, f.r) | m_chan(c.g, f.g) | m_chan(c.b, f.b);
    if (f.cat == SAPH_PIXTYPE_ARGB) v = v | m_chan(c.a, f.a);
    return v % (64'd1 << s);
  endfunction

  task automatic m_build(input pixfmt_t f);
    int s = int'(f.size) + 1;
    int ppw = BUS_W / s;
    int k = 0;
    longint unsigned word = 0;
    exp_q.delete();
    for (int i = 0; i < px_q.size(); i++) begin
      word = word | (m_pix(f, px_q[i]) << (k * s));
      if (k == ppw - 1 || i == px_q.size() - 1) begin
        int nbytes = ((k + 1) * s + 7) / 8;
        exp_q.push_back({word[31:0], 4'((1 << nbytes) - 1), (i == px_q.size() - 1)});
        word = 0;
        k = 0;
      end else begin
        k++;
      end
    end
  endtask

  function automatic pixfmt_t mk_fmt(logic [3:0] cat, logic [4:0] size,
                                     chan_t a, chan_t r, chan_t g, chan_t b);
    pixfmt_t f;
    f.cat = cat; f.size = size; f.a = a; f.r = r; f.g = g; f.b = b;
    return f;
  endfunction

  function automatic pixfmt_t fmt565();
    return mk_fmt(SAPH_PIXTYPE_RGB, 5'd15, chan_t'(8'h00), chan_t'({5'd11, 3'd4}),
                  chan_t'({5'd5, 3'd5}), chan_t'({5'd0, 3'd4}));
  endfunction

  function automatic pixfmt_t fmt8888();
    return mk_fmt(SAPH_PIXTYPE_ARGB, 5'd31, chan_t'({5'd24, 3'd7}), chan_t'({5'd16, 3'd7}),
                  chan_t'({5'd8, 3'd7}), chan_t'({5'd0, 3'd7}));
  endfunction

  // ---------------- drivers ----------------
  task automatic cfg_go(input pixfmt_t f);
    cfg_fmt = f;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_px(input color_t c, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_color = c;
    bus.in_last  = last;
    bus.in_x     = 2'($urandom_range(0, 3));
    bus.in_y     = 2'($urandom_range(0, 3));
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_last();
    int n = 0;
    while (!(got_q.size() > 0 && got_q[$].l) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL last_timeout words=%0d required out_last", got_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic run_px(input pixfmt_t f);
    got_q.delete();
    cfg_go(f);
    for (int i = 0; i < px_q.size(); i++) send_px(px_q[i], i == px_q.size() - 1);
    wait_last();
    m_build(f);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_strb, bus.out_last} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out got %h required 0", {bus.out_valid, bus.out_data, bus.out_strb, bus.out_last});
    end
    checks++;
    if ({cfg_err, busy, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000", {cfg_err, busy, bus.in_ready});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b required 0", busy); end
  endtask

  task automatic test_rgb565();
    px_q = '{color_t'(32'hFFFF8000), color_t'(32'hFF0000FF), color_t'(32'hFF0000FF)};
    run_px(fmt565());
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL v1_count got %0d required 2", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== {32'h001F_FC00, 4'hF, 1'b0}) begin errors++; $display("FAIL v1_word0 got %h required %h", got_q[0], {32'h001F_FC00, 4'hF, 1'b0}); end
      checks++;
      if (got_q[1] !== {32'h0000_001F, 4'h3, 1'b1}) begin errors++; $display("FAIL v1_word1 got %h required %h", got_q[1], {32'h0000_001F, 4'h3, 1'b1}); end
    end
    px_q = '{color_t'(32'hFFFF8000), color_t'(32'hFFFF8000), color_t'(32'hFFFF8000)};
    run_px(fmt565());
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL v2_count got %0d required 2", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== {32'hFC00_FC00, 4'hF, 1'b0}) begin errors++; $display("FAIL v2_word0 got %h required %h", got_q[0], {32'hFC00_FC00, 4'hF, 1'b0}); end
      checks++;
      if (got_q[1] !== {32'h0000_FC00, 4'h3, 1'b1}) begin errors++; $display("FAIL v2_word1 got %h required %h", got_q[1], {32'h0000_FC00, 4'h3, 1'b1}); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL v2_idle busy=%b required 0", busy); end
  endtask

  task automatic test_stall();
    wrd_t hold;
    px_q.delete();
    for (int i = 0; i < 4; i++) px_q.push_back(color_t'($urandom));
    rdy_force = 1'b0;
    @(posedge clk); #1;
    fork
      run_px(fmt8888());
      begin
        int n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        hold = {bus.out_data, bus.out_strb, bus.out_last};
        repeat (5) begin
          @(negedge clk);
          checks++;
          if ({bus.out_valid, bus.out_data, bus.out_strb, bus.out_last} !== {1'b1, hold}) begin
            errors++;
            $display("FAIL stall_hold got %h required %h", {bus.out_valid, bus.out_data, bus.out_strb, bus.out_last}, {1'b1, hold});
          end
          checks++;
          if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b required 0", bus.in_ready); end
        end
        rdy_force = 1'b1;
      end
    join
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_cfg_err();
    pixfmt_t bad = fmt565();
    pixfmt_t badcat = fmt565();
    bad.size = 5'd23;
    badcat.cat = 4'd2;
    cfg_go(bad);
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if ({cfg_err, busy, bus.in_ready} !== 3'b100) begin errors++; $display("FAIL cfg_bad_size got %b required 100", {cfg_err, busy, bus.in_ready}); end
    bus.in_valid = 1'b0;
    cfg_go(fmt565());
    checks++;
    if ({cfg_err, busy} !== 2'b01) begin errors++; $display("FAIL cfg_good got %b required 01", {cfg_err, busy}); end
    cfg_go(badcat);
    checks++;
    if ({cfg_err, busy} !== 2'b01) begin errors++; $display("FAIL cfg_ignored_in_run got %b required 01", {cfg_err, busy}); end
    got_q.delete();
    send_px(color_t'(32'hFFFF8000), 1'b1);
    wait_last();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {32'h0000_FC00, 4'h3, 1'b1}) begin
      errors++;
      $display("FAIL cfg_run_word got n=%0d w=%h required %h", got_q.size(), got_q[0], {32'h0000_FC00, 4'h3, 1'b1});
    end
    cfg_go(badcat);
    checks++;
    if ({cfg_err, busy} !== 2'b10) begin errors++; $display("FAIL cfg_bad_cat got %b required 10", {cfg_err, busy}); end
  endtask

  task automatic test_s1();
    pixfmt_t f = mk_fmt(SAPH_PIXTYPE_RGB, 5'd0, chan_t'(8'h00), chan_t'({5'd31, 3'd0}),
                        chan_t'({5'd0, 3'd0}), chan_t'({5'd30, 3'd7}));
    px_q.delete();
    for (int i = 0; i < 9; i++)
      px_q.push_back({8'($urandom), 8'($urandom), (i % 2 == 0) ? 8'h80 : 8'h00, 8'($urandom)});
    run_px(f);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {32'h0000_0155, 4'h3, 1'b1}) begin
      errors++;
      $display("FAIL s1_word got n=%0d w=%h required %h", got_q.size(), got_q[0], {32'h0000_0155, 4'h3, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    cfg_go(fmt565());
    send_px(color_t'(32'hFFFF8000), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_strb, bus.out_last, busy, bus.in_ready, cfg_err} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mid got %h required 0", {bus.out_valid, bus.out_data, bus.out_strb, bus.out_last, busy, bus.in_ready, cfg_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    px_q = '{color_t'(32'hFF0000FF)};
    run_px(fmt565());
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {32'h0000_001F, 4'h3, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_slot0 got n=%0d w=%h required %h", got_q.size(), got_q[0], {32'h0000_001F, 4'h3, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    px_q.delete();
    for (int i = 0; i < 8; i++) px_q.push_back(color_t'($urandom));
    fire_q.delete();
    run_px(fmt8888());
    checks++;
    if (fire_q.size() != 8 || fire_q[7] - fire_q[0] != 7) begin
      errors++;
      $display("FAIL b2b_rate got n=%0d span=%0d required n=8 span=7", fire_q.size(), fire_q[$] - fire_q[0]);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [4:0] sizes [6] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31};
    rdy_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      pixfmt_t f = mk_fmt(4'($urandom_range(0, 1)), sizes[$urandom_range(0, 5)],
                          chan_t'(8'($urandom)), chan_t'(8'($urandom)),
                          chan_t'(8'($urandom)), chan_t'(8'($urandom)));
      int n = $urandom_range(1, 24);
      px_q.delete();
      for (int i = 0; i < n; i++) px_q.push_back(color_t'($urandom));
      run_px(f);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d required %0d", r, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h required %h", r, i, got_q[i], exp_q[i]); end
      end
    end
    rdy_rand = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_color = '0;
    bus.in_x     = 2'd0;
    bus.in_y     = 2'd0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_rgb565();
    test_stall();
    test_cfg_err();
    test_s1();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
